// File: rtl/dmem_init_loader.sv
// Streams a length-prefixed little-endian word image from a byte source into the data-memory init port.
// Optional checksum trailer after the data words: define DMEM_INIT_LOADER_CSUM_EN.
module dmem_init_loader #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           MAX_WORDS  = 65536
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx_valid,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_stall,
  output logic [3:0]            o_init_wen,
  output logic [ADDR_WIDTH-1:0] o_init_addr,
  output logic [31:0]           o_init_data,
  output logic                  o_init_done,
  output logic                  o_error,
  output logic [16:0]           o_words
);

  localparam int unsigned CNT_W  = 17;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
`ifdef DMEM_INIT_LOADER_CSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t                state, state_n;
  logic [1:0]            idx, idx_n;
  logic [23:0]           acc, acc_n;
  logic [CNT_W-1:0]      len, len_n;
  logic [CNT_W-1:0]      rcv, rcv_n;
  logic [CNT_W-1:0]      words, words_n;
  logic                  pend, pend_n;
  logic [WORD_W-1:0]     pdata, pdata_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic                  byte_in;
  logic                  word_done;
  logic                  accept;
  logic [WORD_W-1:0]     full_word;
`ifdef DMEM_INIT_LOADER_CSUM_EN
  logic [WORD_W-1:0]     sum, sum_n;
  logic                  csum_ok, csum_ok_n;
`endif

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_LEN;
      idx     <= '0;
      acc     <= '0;
      len     <= '0;
      rcv     <= '0;
      words   <= '0;
      pend    <= 1'b0;
      pdata   <= '0;
      addr    <= BASE_ADDR;
`ifdef DMEM_INIT_LOADER_CSUM_EN
      sum     <= '0;
      csum_ok <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      acc     <= acc_n;
      len     <= len_n;
      rcv     <= rcv_n;
      words   <= words_n;
      pend    <= pend_n;
      pdata   <= pdata_n;
      addr    <= addr_n;
`ifdef DMEM_INIT_LOADER_CSUM_EN
      sum     <= sum_n;
      csum_ok <= csum_ok_n;
`endif
    end
  end

  // Next-state, byte assembly and write handshake
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    acc_n     = acc;
    len_n     = len;
    rcv_n     = rcv;
    words_n   = words;
    pend_n    = pend;
    pdata_n   = pdata;
    addr_n    = addr;
`ifdef DMEM_INIT_LOADER_CSUM_EN
    sum_n     = sum;
    csum_ok_n = csum_ok;
`endif

    byte_in = 1'b0;
    if (i_rx_valid) begin
      case (state)
        S_LEN:   byte_in = 1'b1;
        S_DATA:  byte_in = (rcv != len);
`ifdef DMEM_INIT_LOADER_CSUM_EN
        S_CSUM:  byte_in = !csum_ok;
`endif
        default: byte_in = 1'b0;
      endcase
    end

    full_word = {i_rx_data, acc};
    word_done = byte_in && (idx == 2'd3);
    accept    = pend && !i_stall;

    if (byte_in) begin
      case (idx)
        2'd0:    acc_n[7:0]   = i_rx_data;
        2'd1:    acc_n[15:8]  = i_rx_data;
        2'd2:    acc_n[23:16] = i_rx_data;
        default: acc_n        = acc;
      endcase
      idx_n = idx + 2'd1;
    end

    if (accept) begin
      addr_n  = addr + ADDR_WIDTH'(4);
      words_n = words + CNT_W'(1);
      pend_n  = 1'b0;
    end

    case (state)
      S_LEN: begin
        if (word_done) begin
          if (full_word == '0) begin
`ifdef DMEM_INIT_LOADER_CSUM_EN
            state_n = S_CSUM;
`else
            state_n = S_DONE;
`endif
          end else if (full_word > 32'(MAX_WORDS)) begin
            state_n = S_ERR;
          end else begin
            len_n   = CNT_W'(full_word);
            state_n = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (word_done) begin
          // A finished word with the previous write still blocked has nowhere to go
          if (pend && i_stall) begin
            state_n = S_ERR;
            pend_n  = 1'b0;
          end else begin
            pend_n  = 1'b1;
            pdata_n = full_word;
            rcv_n   = rcv + CNT_W'(1);
`ifdef DMEM_INIT_LOADER_CSUM_EN
            sum_n   = sum + full_word;
            if (rcv_n == len) state_n = S_CSUM;
`endif
          end
        end
`ifndef DMEM_INIT_LOADER_CSUM_EN
        else if (rcv == len && !pend_n) begin
          state_n = S_DONE;
        end
`endif
      end

`ifdef DMEM_INIT_LOADER_CSUM_EN
      S_CSUM: begin
        if (word_done) begin
          if (full_word != sum) begin
            state_n = S_ERR;
            pend_n  = 1'b0;
          end else begin
            csum_ok_n = 1'b1;
          end
        end
        // Done only once the trailer matched and the last write has drained
        if (state_n == S_CSUM && csum_ok_n && !pend_n) state_n = S_DONE;
      end
`endif

      S_ERR:   pend_n = 1'b0;
      default: state_n = state;
    endcase
  end

  assign o_init_wen  = pend ? 4'hf : 4'h0;
  assign o_init_addr = addr;
  assign o_init_data = pdata;
  assign o_init_done = (state == S_DONE);
  assign o_error     = (state == S_ERR);
  assign o_words     = words;

endmodule

// File: tb/tb_dmem_init_loader.sv
// Scoreboard bench for dmem_init_loader: image parser model predicts writes, a monitor checks them.
// Follows DMEM_INIT_LOADER_CSUM_EN to append/verify checksum trailers.
module tb_dmem_init_loader;

  localparam int unsigned AW   = 32;
  localparam logic [31:0] BASE = 32'h0;
  localparam int unsigned MAXW = 65536;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          stall;
  logic          stall_req;
  logic          rand_stall;
  logic          stall_r = 1'b0;
  int            run = 0;
  logic [3:0]    wen;
  logic [AW-1:0] addr;
  logic [31:0]   data;
  logic          done;
  logic          error;
  logic [16:0]   words;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] bq[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_acc = 0;
  bit         acc_seen = 0;
  bit         prev_done = 0;

  dmem_init_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx_valid  (rx_valid),
    .i_rx_data   (rx_data),
    .i_stall     (stall),
    .o_init_wen  (wen),
    .o_init_addr (addr),
    .o_init_data (data),
    .o_init_done (done),
    .o_error     (error),
    .o_words     (words)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Random stall never lasts more than 2 cycles, so spaced bytes cannot overflow
  always @(posedge clk) begin
    if (run >= 2) begin
      stall_r <= 1'b0; run <= 0;
    end else if ($urandom_range(0, 2) == 0) begin
      stall_r <= 1'b1; run <= run + 1;
    end else begin
      stall_r <= 1'b0; run <= 0;
    end
  end
  assign stall = rand_stall ? stall_r : stall_req;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // Monitor: every accepted write is popped and compared; done must follow the last write
  always @(negedge clk) begin
    wr_t e;
    if (rst) begin
      acc_seen  = 0;
      prev_done = 0;
    end else begin
      if (wen != 4'h0 && !stall) begin
        check("wen_value", 64'(wen), 64'hf);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(data), 64'hffff_ffff_ffff_ffff);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 64'(addr), 64'(e.a));
          check("write_data", 64'(data), 64'(e.d));
        end
        acc_seen = 1;
        last_acc = cyc;
      end
      if (done && !prev_done) begin
        check("done_with_writes_outstanding", 64'(exp_q.size()), 64'd0);
        if (acc_seen) begin
`ifdef DMEM_INIT_LOADER_CSUM_EN
          check("done_after_last_write", 64'(cyc > last_acc), 64'd1);
`else
          check("done_timing", 64'(cyc), 64'(last_acc + 1));
`endif
        end
      end
      prev_done = done;
    end
  end

  // Reference model: parse the byte image, queue expected writes, return 0=done 1=error
  function automatic int predict();
    logic [31:0] n, w, sum, cs;
    int p;
    n = {bq[3], bq[2], bq[1], bq[0]};
    if (n > MAXW) return 1;
    sum = '0;
    for (int i = 0; i < int'(n); i++) begin
      p = 4 + 4 * i;
      w = {bq[p+3], bq[p+2], bq[p+1], bq[p]};
      exp_q.push_back('{a: BASE + AW'(4 * i), d: w});
      sum = sum + w;
    end
`ifdef DMEM_INIT_LOADER_CSUM_EN
    p  = 4 + 4 * int'(n);
    cs = {bq[p+3], bq[p+2], bq[p+1], bq[p]};
    if (cs != sum) return 1;
`else
    cs = sum;
`endif
    return 0;
  endfunction

  function automatic void add_word(logic [31:0] w);
    for (int k = 0; k < 4; k++) bq.push_back(w[8*k +: 8]);
  endfunction

  // Checksum trailer only exists when the feature is built in
  function automatic void finish_image(logic [31:0] sum);
`ifdef DMEM_INIT_LOADER_CSUM_EN
    add_word(sum);
`else
    if (sum == 32'hx) bq.push_back(8'h0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk); #1;
    rx_data = 8'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) tick();
  endtask

  task automatic send_range(input int from, input int to, input int gmin, input int gmax);
    for (int i = from; i < to; i++) send_byte(bq[i], $urandom_range(gmin, gmax));
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_wen",   64'(wen),   64'd0);
    check("rst_addr",  64'(addr),  64'(BASE));
    check("rst_data",  64'(data),  64'd0);
    check("rst_done",  64'(done),  64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_words", 64'(words), 64'd0);
  endtask

  task automatic finish_check(input int res, input int n_exp);
    int n = 0;
    while (!done && !error && n < 400) begin tick(); n++; end
    check("finished_in_budget", 64'(done | error), 64'd1);
    check("final_done",  64'(done),  64'(res == 0));
    check("final_error", 64'(error), 64'(res == 1));
    check("final_words", 64'(words), 64'(n_exp));
    check("final_wen",   64'(wen),   64'd0);
    tick(); tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int res, n_exp, n;
    logic [31:0] w, sum;
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; stall_req = 1'b0; rand_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Two-word load, no stall, with latency and single-cycle wen checks
    do_reset();
    bq = {}; add_word(32'd2); add_word(32'h12345678); add_word(32'hDEADBEEF);
    finish_image(32'h12345678 + 32'hDEADBEEF);
    res = predict(); n_exp = exp_q.size();
    for (int i = 0; i < bq.size(); i++) begin
      send_byte(bq[i], 0);
      if (i == 7) check("first_wen_latency", 64'(wen), 64'hf);
      if (i == 8) check("wen_one_cycle", 64'(wen), 64'd0);
    end
    finish_check(res, n_exp);

    // Stall held for 5 cycles after the word completes
    do_reset();
    bq = {}; add_word(32'd1); add_word(32'hCAFEF00D); finish_image(32'hCAFEF00D);
    res = predict(); n_exp = exp_q.size();
    stall_req = 1'b1;
    send_range(0, 8, 0, 0);
    for (int c = 0; c < 5; c++) begin
      check("hold_wen",  64'(wen),  64'hf);
      check("hold_addr", 64'(addr), 64'(BASE));
      check("hold_data", 64'(data), 64'hCAFEF00D);
      tick();
    end
    stall_req = 1'b0;
    send_range(8, bq.size(), 0, 0);
    finish_check(res, n_exp);

    // Overflow: second word completes while the first is still stalled
    do_reset();
    bq = {}; add_word(32'd2); add_word(32'h1); add_word(32'h2);
    stall_req = 1'b1;
    send_range(0, bq.size(), 0, 0);
    check("ovf_error", 64'(error), 64'd1);
    check("ovf_done",  64'(done),  64'd0);
    check("ovf_wen",   64'(wen),   64'd0);
    stall_req = 1'b0;
    repeat (3) tick();
    check("ovf_error_sticky", 64'(error), 64'd1);
    check("ovf_words",        64'(words), 64'd0);

    // Zero length
    do_reset();
    bq = {}; add_word(32'd0); finish_image(32'd0);
    res = predict(); n_exp = exp_q.size();
    send_range(0, bq.size(), 0, 0);
    finish_check(res, n_exp);

    // Oversize length
    do_reset();
    bq = {}; add_word(32'h0001_0001);
    res = predict(); n_exp = exp_q.size();
    send_range(0, bq.size(), 0, 0);
    finish_check(res, n_exp);

    // Reset in the middle of the first data word
    do_reset();
    bq = {}; add_word(32'd1); bq.push_back(8'hAA); bq.push_back(8'hBB);
    send_range(0, bq.size(), 0, 0);
    do_reset();
    bq = {}; add_word(32'd1); add_word(32'h0000_00AA); finish_image(32'h0000_00AA);
    res = predict(); n_exp = exp_q.size();
    send_range(0, bq.size(), 0, 0);
    finish_check(res, n_exp);

`ifdef DMEM_INIT_LOADER_CSUM_EN
    // Checksum trailer: matching and mismatching
    for (int t = 0; t < 2; t++) begin
      do_reset();
      bq = {}; add_word(32'd2); add_word(32'd1); add_word(32'd2); add_word(t == 0 ? 32'd3 : 32'd4);
      res = predict(); n_exp = exp_q.size();
      check("csum_model_outcome", 64'(res), 64'(t));
      send_range(0, bq.size(), 0, 0);
      finish_check(res, n_exp);
    end
`endif

    // Randomized images with random byte gaps and short random stalls
    rand_stall = 1'b1;
    for (int it = 0; it < 25; it++) begin
      do_reset();
      bq = {};
      if ($urandom_range(0, 7) == 0) begin
        add_word(32'(MAXW) + 32'($urandom_range(1, 1000)));
      end else begin
        n = $urandom_range(1, 8);
        add_word(32'(n));
        sum = '0;
        for (int i = 0; i < n; i++) begin
          w = $urandom; add_word(w); sum = sum + w;
        end
        if ($urandom_range(0, 4) == 0) sum = sum + 32'd1;
        finish_image(sum);
      end
      res = predict(); n_exp = exp_q.size();
      repeat ($urandom_range(0, 3)) bq.push_back(8'($urandom));
      send_range(0, bq.size(), 1, 3);
      finish_check(res, n_exp);
    end
    rand_stall = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
